// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between instruction fetch
//   (IF) and the MEM-stage data access. One access is in flight at a time.
//   Each access runs IDLE -> BUSY_x -> RESP -> IDLE. The memory strobe fires
//   in the first BUSY cycle. Read data is registered in the cycle it is valid
//   and then presented with a one-cycle ready pulse. Data normally wins a tie.
//   After STARVE_MAX consecutive tie losses, IF is forced to win.
//
// Ports
//   clk, reset_n           clock (rising edge), synchronous active-low reset
//   if_req/if_addr         fetch request and address
//   if_rdata/if_ready      fetched word and its one-cycle completion pulse
//   d_req/d_we/d_addr/
//   d_wdata                data request, direction, address and store data
//   d_rdata/d_ready        load data and its one-cycle completion pulse
//   stall_if/stall_mem     request pending and not completing this cycle
//   mem_en/mem_we/
//   mem_addr/mem_wdata     registered memory command (mem_en is a 1-cycle strobe)
//   mem_rdata              memory read data, valid MEM_LAT cycles after mem_en
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D, S_RESP} state_e;

  localparam int            SW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [3:0]    LAT_INIT   = 4'(MEM_LAT);

  state_e            state_q,     state_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [3:0]        lat_cnt_q,   lat_cnt_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
  logic              if_ready_q,  if_ready_d;
  logic              d_ready_q,   d_ready_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              grant_if;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;
    mem_en_d     = 1'b0;
    grant_if     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          // Data wins ties unless IF has lost STARVE_MAX times in a row.
          grant_if  = if_req && (!d_req || ((STARVE_MAX != 0) && (starve_cnt_q == STARVE_LIM)));
          lat_cnt_d = LAT_INIT;
          mem_en_d  = 1'b1;
          if (grant_if) begin
            state_d      = S_BUSY_I;
            mem_addr_d   = if_addr;
            mem_we_d     = 1'b0;
            starve_cnt_d = '0;
          end else begin
            state_d     = S_BUSY_D;
            mem_addr_d  = d_addr;
            mem_we_d    = d_we;
            mem_wdata_d = d_wdata;
            if (if_req && (starve_cnt_q != STARVE_LIM)) starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end

      S_BUSY_I, S_BUSY_D: begin
        // lat_cnt counts the cycles left until mem_rdata is valid.
        // Zero marks the data cycle, which is MEM_LAT cycles after mem_en.
        if (lat_cnt_q == 4'd0) begin
          state_d = S_RESP;
          if (state_q == S_BUSY_I) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            d_rdata_d  = mem_rdata;
            d_ready_d  = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end

      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state_q      <= S_IDLE;
      starve_cnt_q <= '0;
      lat_cnt_q    <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_ready_q   <= if_ready_d;
      d_ready_q    <= d_ready_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. DUT "a" uses MEM_LAT=2 and
//   STARVE_MAX=4. DUT "b" uses MEM_LAT=1 and STARVE_MAX=0. Each DUT has a
//   small memory model. The model returns addr ^ 0x2048_0005 exactly MEM_LAT
//   cycles after mem_en and returns all-ones in every other cycle.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam logic [31:0] KEY  = 32'h2048_0005;
  localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- DUT a: MEM_LAT=2, STARVE_MAX=4 ----------------
  logic        a_reset_n, a_if_req, a_d_req, a_d_we;
  logic [31:0] a_if_addr, a_d_addr, a_d_wdata, a_mem_rdata;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
  logic        a_if_ready, a_d_ready, a_stall_if, a_stall_mem, a_mem_en, a_mem_we;
  logic [31:0] a_p0 = JUNK, a_p1 = JUNK;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_a (
    .clk(clk), .reset_n(a_reset_n),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_ready(a_d_ready),
    .stall_if(a_stall_if), .stall_mem(a_stall_mem),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
  );

  always @(posedge clk) begin
    a_p0 <= a_mem_en ? (a_mem_addr ^ KEY) : JUNK;
    a_p1 <= a_p0;
  end
  assign a_mem_rdata = a_p1;

  // ---------------- DUT b: MEM_LAT=1, STARVE_MAX=0 ----------------
  logic        b_reset_n, b_if_req, b_d_req, b_d_we;
  logic [31:0] b_if_addr, b_d_addr, b_d_wdata, b_mem_rdata;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic        b_if_ready, b_d_ready, b_stall_if, b_stall_mem, b_mem_en, b_mem_we;
  logic [31:0] b_p0 = JUNK;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(0)) u_b (
    .clk(clk), .reset_n(b_reset_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready),
    .stall_if(b_stall_if), .stall_mem(b_stall_mem),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  always @(posedge clk) b_p0 <= b_mem_en ? (b_mem_addr ^ KEY) : JUNK;
  assign b_mem_rdata = b_p0;

  // ---------------- stimulus ----------------
  int          g_cyc  [16];
  logic [31:0] g_addr [16];
  int          n_g;
  int          r_cyc  [8];
  logic [31:0] r_data [8];
  int          n_r;
  int          cnt_a, cnt_b;
  int          en_cyc, rdy_cyc;
  logic [31:0] rdy_data;

  initial begin
    a_reset_n = 1'b0; a_if_req = 1'b1; a_d_req = 1'b1; a_d_we = 1'b0;
    a_if_addr = '0; a_d_addr = '0; a_d_wdata = '0;
    b_reset_n = 1'b0; b_if_req = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_if_addr = '0; b_d_addr = '0; b_d_wdata = '0;

    // Reset held for 3 cycles with both requests high.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mem_en", a_mem_en, 1'b0);
      check("rst_ready", {a_if_ready, a_d_ready}, 2'b00);
    end
    check("rst_mem_we", a_mem_we, 1'b0);
    check("rst_mem_addr", a_mem_addr, 32'h0);
    check("rst_mem_wdata", a_mem_wdata, 32'h0);
    check("rst_rdata", {a_if_rdata, a_d_rdata}, 64'h0);
    a_if_req = 1'b0; a_d_req = 1'b0; a_reset_n = 1'b1;
    step();

    // Single IF access. The current cycle is cycle 0.
    a_if_req = 1'b1; a_if_addr = 32'h0040_0000;
    step();                                           // cycle 1
    check("if1_mem_en_c1", a_mem_en, 1'b1);
    check("if1_mem_addr", a_mem_addr, 32'h0040_0000);
    check("if1_mem_we", a_mem_we, 1'b0);
    step();                                           // cycle 2
    check("if1_mem_en_c2", a_mem_en, 1'b0);
    check("if1_stall_if_c2", a_stall_if, 1'b1);
    step();                                           // cycle 3
    check("if1_ready_c3", a_if_ready, 1'b0);
    check("if1_mem_rdata_c3", a_mem_rdata, 32'h2008_0005);
    step();                                           // cycle 4
    check("if1_ready_c4", a_if_ready, 1'b1);
    check("if1_rdata", a_if_rdata, 32'h2008_0005);
    check("if1_stall_if_c4", a_stall_if, 1'b0);
    a_if_req = 1'b0;
    step();                                           // cycle 5
    check("if1_ready_c5", a_if_ready, 1'b0);

    // Simultaneous requests. Data wins; IF is served after one IDLE cycle.
    a_if_req = 1'b1; a_if_addr = 32'h0040_0100;
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h1000_0004; a_d_wdata = 32'hDEAD_BEEF;
    step();                                           // cycle 1
    check("sim_mem_en_c1", a_mem_en, 1'b1);
    check("sim_mem_we_c1", a_mem_we, 1'b1);
    check("sim_mem_addr_c1", a_mem_addr, 32'h1000_0004);
    check("sim_mem_wdata_c1", a_mem_wdata, 32'hDEAD_BEEF);
    check("sim_stall_mem_c1", a_stall_mem, 1'b1);
    step(); step();                                   // cycle 3
    check("sim_d_ready_c3", a_d_ready, 1'b0);
    step();                                           // cycle 4
    check("sim_d_ready_c4", a_d_ready, 1'b1);
    check("sim_stall_mem_c4", a_stall_mem, 1'b0);
    a_d_req = 1'b0; a_d_we = 1'b0;
    step();                                           // cycle 5 (IDLE)
    check("sim_mem_en_c5", a_mem_en, 1'b0);
    step();                                           // cycle 6
    check("sim_if_mem_en_c6", a_mem_en, 1'b1);
    check("sim_if_mem_we_c6", a_mem_we, 1'b0);
    check("sim_if_mem_addr_c6", a_mem_addr, 32'h0040_0100);
    step(); step();                                   // cycle 8
    check("sim_if_ready_c8", a_if_ready, 1'b0);
    step();                                           // cycle 9
    check("sim_if_ready_c9", a_if_ready, 1'b1);
    check("sim_if_rdata", a_if_rdata, 32'h2008_0105);
    a_if_req = 1'b0;
    step();                                           // cycle 10 (IDLE)

    // Starvation: both requests held. Expected grant order is D D D D I D D D D I.
    a_if_req = 1'b1; a_if_addr = 32'h0040_0200;
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h1000_0010;
    n_g = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (a_mem_en) begin
        if (n_g < 16) begin
          g_cyc[n_g] = k;
          g_addr[n_g] = a_mem_addr;
        end
        n_g++;
      end
    end
    a_if_req = 1'b0; a_d_req = 1'b0;
    check("starve_n_grants", n_g, 10);
    for (int i = 0; i < 10 && i < n_g; i++) begin
      check($sformatf("starve_g%0d_cyc", i), g_cyc[i], 1 + 5 * i);
      check($sformatf("starve_g%0d_addr", i), g_addr[i],
            (i % 5 == 4) ? 32'h0040_0200 : 32'h1000_0010);
    end
    step();

    // Reset in the second BUSY_D cycle abandons the access.
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h1000_0020;  // cycle 0
    step();                                           // cycle 1
    check("rma_mem_en_c1", a_mem_en, 1'b1);
    step();                                           // cycle 2
    a_reset_n = 1'b0; a_d_req = 1'b0;
    step();                                           // cycle 3
    check("rma_ready", {a_if_ready, a_d_ready}, 2'b00);
    check("rma_mem_en", a_mem_en, 1'b0);
    check("rma_mem_we", a_mem_we, 1'b0);
    check("rma_mem_addr", a_mem_addr, 32'h0);
    check("rma_mem_wdata", a_mem_wdata, 32'h0);
    check("rma_if_rdata", a_if_rdata, 32'h0);
    check("rma_d_rdata", a_d_rdata, 32'h0);
    a_reset_n = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (a_d_ready) cnt_a++;
      if (a_mem_en) cnt_b++;
    end
    check("rma_no_d_ready", cnt_a, 0);
    check("rma_no_mem_en", cnt_b, 0);

    // A fresh IF request after the abandoned access completes normally.
    a_if_req = 1'b1; a_if_addr = 32'h0040_0300;
    en_cyc = -1; rdy_cyc = -1; rdy_data = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (a_mem_en && en_cyc < 0) en_cyc = k;
      if (a_if_ready) begin
        rdy_cyc = k;
        rdy_data = a_if_rdata;
        break;
      end
    end
    a_if_req = 1'b0;
    check("rma_if_en_cyc", en_cyc, 1);
    check("rma_if_ready_cyc", rdy_cyc, 4);
    check("rma_if_rdata", rdy_data, 32'h2008_0305);

    // DUT b: with pure data priority, continuous d_req shuts IF out.
    b_if_req = 1'b1; b_if_addr = 32'h0040_0400;
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h1000_0040;
    b_reset_n = 1'b1;                                 // this cycle is cycle 0 (IDLE)
    n_g = 0; n_r = 0; cnt_b = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (b_mem_en) begin
        if (b_mem_addr == 32'h0040_0400) cnt_b++;
        n_g++;
      end
      if (b_d_ready) begin
        if (n_r < 8) begin
          r_cyc[n_r] = k;
          r_data[n_r] = b_d_rdata;
        end
        n_r++;
      end
      if (k == 2) check("b_stall_if_busy", b_stall_if, 1'b1);
    end
    check("b_n_grants", n_g, 4);
    check("b_no_if_grant", cnt_b, 0);
    check("b_n_d_ready", n_r, 4);
    for (int i = 0; i < 4 && i < n_r; i++) begin
      check($sformatf("b_d_ready%0d_cyc", i), r_cyc[i], 3 + 4 * i);
      check($sformatf("b_d_rdata%0d", i), r_data[i], 32'h3048_0045);
    end
    b_d_req = 1'b0;                                   // cycle 16 (IDLE)
    step();                                           // cycle 17
    check("b_if_mem_en", b_mem_en, 1'b1);
    check("b_if_mem_addr", b_mem_addr, 32'h0040_0400);
    step();                                           // cycle 18
    check("b_if_ready_c18", b_if_ready, 1'b0);
    step();                                           // cycle 19
    check("b_if_ready_c19", b_if_ready, 1'b1);
    check("b_if_rdata", b_if_rdata, 32'h2008_0405);
    b_if_req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
